// File: rtl/arb2to1.sv
// Round-robin 2:1 valid/ready arbiter with a one-entry output register and select flag (1 = A).
// Latency 1 cycle, one word per cycle; both readys drop while a held output word is not taken.
module arb2to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_sel,
    input  logic             y_ready
);

    logic pri;
    logic load;
    logic grant_a;
    logic grant_b;

    assign load    = ~y_valid | y_ready;
    assign grant_a = a_valid & (pri | ~b_valid);
    assign grant_b = b_valid & (~pri | ~a_valid);

    // Readys look only at the other source's valid, so there is no valid -> own-ready path.
    assign a_ready = load & (pri | ~b_valid);
    assign b_ready = load & (~pri | ~a_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri     <= 1'b1;
            y_valid <= 1'b0;
            y_data  <= '0;
            y_sel   <= 1'b0;
        end else if (load) begin
            if (grant_a) begin
                y_data  <= a_data;
                y_sel   <= 1'b1;
                y_valid <= 1'b1;
                pri     <= 1'b0;
            end else if (grant_b) begin
                y_data  <= b_data;
                y_sel   <= 1'b0;
                y_valid <= 1'b1;
                pri     <= 1'b1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb2to1.sv
// Directed and random-soak bench for arb2to1.
module tb_arb2to1;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_sel;
    logic             y_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    arb2to1 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_sel   (y_sel),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        check({tag, ".y_valid"}, {31'd0, y_valid}, {31'd0, v});
        check({tag, ".y_data"}, {24'd0, y_data}, {24'd0, d});
        check({tag, ".y_sel"}, {31'd0, y_sel}, {31'd0, s});
    endtask

    logic [7:0] alt_data [6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
    logic       alt_sel  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [7:0] ia, ib, oa, ob;
        logic       acc_a, acc_b, take, both, a_turn;
        logic [7:0] sd;
        logic       ss;

        // Reset state
        #3;
        check_out("reset", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // Load a word, then reset asynchronously mid-stream
        a_valid = 1'b1; a_data = 8'h33; y_ready = 1'b0;
        tick();
        check_out("preload", 1'b1, 8'h33, 1'b1);
        a_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // First simultaneous request after reset goes to A
        a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22; y_ready = 1'b1;
        #1;
        check("first.a_ready", {31'd0, a_ready}, 32'd1);
        check("first.b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        check_out("first_a", 1'b1, 8'h11, 1'b1);
        a_valid = 1'b0;
        tick();
        check_out("then_b", 1'b1, 8'h22, 1'b0);
        b_valid = 1'b0;
        tick();
        check_out("drain_only", 1'b0, 8'h22, 1'b0);

        // Fair alternation under sustained contention
        ia = 8'hA0; ib = 8'hB0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_data = ia; b_data = ib;
            #1;
            acc_a = a_ready; acc_b = b_ready;
            tick();
            check_out($sformatf("alt%0d", k), 1'b1, alt_data[k], alt_sel[k]);
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        check("alt_drain.y_valid", {31'd0, y_valid}, 32'd0);

        // Single requester: B streams back-to-back
        b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_data = 8'hC0 + 8'(k);
            #1;
            check($sformatf("solo%0d.b_ready", k), {31'd0, b_ready}, 32'd1);
            tick();
            check_out($sformatf("solo%0d", k), 1'b1, 8'hC0 + 8'(k), 1'b0);
        end
        a_valid = 1'b1; a_data = 8'hD0; b_data = 8'hD4;
        tick();
        check_out("after_solo", 1'b1, 8'hD0, 1'b1);
        a_valid = 1'b0;
        tick();
        check_out("after_solo_b", 1'b1, 8'hD4, 1'b0);
        b_valid = 1'b0;

        // Backpressure: hold 0x5C with both sources waiting
        a_valid = 1'b1; a_data = 8'h5C;
        tick();
        check_out("bp_load", 1'b1, 8'h5C, 1'b1);
        a_data = 8'hA5; b_valid = 1'b1; b_data = 8'hB0; y_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d.a_ready", k), {31'd0, a_ready}, 32'd0);
            check($sformatf("bp%0d.b_ready", k), {31'd0, b_ready}, 32'd0);
            tick();
            check_out($sformatf("bp%0d", k), 1'b1, 8'h5C, 1'b1);
        end
        y_ready = 1'b1;
        #1;
        check("bp_rel.b_ready", {31'd0, b_ready}, 32'd1);
        check("bp_rel.a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        check_out("bp_rel", 1'b1, 8'hB0, 1'b0);
        b_valid = 1'b0;
        tick();
        check_out("bp_next_a", 1'b1, 8'hA5, 1'b1);
        a_valid = 1'b0;
        tick();
        check("bp_drain.y_valid", {31'd0, y_valid}, 32'd0);

        // Random soak with per-source order scoreboard and fairness check
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        ia = 8'd0; ib = 8'd0; oa = 8'd0; ob = 8'd0; a_turn = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!a_valid) a_valid = ($urandom_range(0, 3) != 0);
            if (!b_valid) b_valid = ($urandom_range(0, 3) != 0);
            a_data  = ia;
            b_data  = ib;
            y_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc_a = a_valid & a_ready;
            acc_b = b_valid & b_ready;
            take  = y_valid & y_ready;
            both  = a_valid & b_valid;
            sd    = y_data;
            ss    = y_sel;
            tick();
            if (take) begin
                if (ss) begin
                    check("soak.a_order", {24'd0, sd}, {24'd0, oa});
                    oa++;
                end else begin
                    check("soak.b_order", {24'd0, sd}, {24'd0, ob});
                    ob++;
                end
            end
            if (both && (acc_a || acc_b))
                check("soak.fair", {31'd0, acc_a}, {31'd0, a_turn});
            if (acc_a || acc_b) a_turn = acc_b;
            if (acc_a) begin ia++; a_valid = 1'b0; end
            if (acc_b) begin ib++; b_valid = 1'b0; end
        end
        a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
        #1;
        if (y_valid) begin
            if (y_sel) oa++; else ob++;
        end
        tick();
        check("soak.a_count", {24'd0, oa}, {24'd0, ia});
        check("soak.b_count", {24'd0, ob}, {24'd0, ib});
        check("soak.empty", {31'd0, y_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb2to1.md
# arb2to1

Two-input round-robin stream arbiter that sits directly upstream of `mux2to1`. It accepts data from two valid/ready sources, picks one per cycle with fair alternation, and registers the winning word. It also registers a select flag whose polarity matches the mux `s` input (1 = source A). The block supplies the select decision and the registered word. The select decision is either wired into `mux2to1` or consumed directly.

## Interface
- `WIDTH`, 8, data width of both sources and the output.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  source A has a word.
- `a_data`  in  WIDTH  source A word.
- `a_ready`  out  1  source A word is taken this cycle.
- `b_valid`  in  1  source B has a word.
- `b_data`  in  WIDTH  source B word.
- `b_ready`  out  1  source B word is taken this cycle.
- `y_valid`  out  1  output register holds a word.
- `y_data`  out  WIDTH  registered winning word.
- `y_sel`  out  1  origin of `y_data`: 1 = A, 0 = B.
- `y_ready`  in  1  downstream takes the output word.

## Operation
- **Transfer rule.** A transfer on any port happens when valid and ready are both high at a rising edge.
- **State.**
  - `pri`: 1 = A has priority.
  - One-entry output register: `y_valid`, `y_data`, `y_sel`.
- **Load enable.** `load = ~y_valid | y_ready`. The register is empty, or it is being drained this cycle.
- **Grants.** Both are combinational.
  - `grant_a = a_valid & (pri | ~b_valid)`
  - `grant_b = b_valid & (~pri | ~a_valid)`
  - At most one grant is high.
- **Ready outputs.**
  - `a_ready = load & (pri | ~b_valid)`
  - `b_ready = load & (~pri | ~a_valid)`
  - Neither ready depends on its own valid.
- **Accepting A** (`load & grant_a`):
  - `y_data <= a_data`, `y_sel <= 1`, `y_valid <= 1`, `pri <= 0`.
- **Accepting B** (`load & grant_b`):
  - `y_data <= b_data`, `y_sel <= 0`, `y_valid <= 1`, `pri <= 1`.
- **Drain without refill** (`y_valid & y_ready`, no grant): `y_valid <= 0`. `y_data` and `y_sel` hold.
- **Holding.** With `y_valid & ~y_ready`, all registers hold and both readys are 0.
- **Priority updates.** `pri` changes only on an accepted transfer. A lone requester does not lose its turn while idle.
- **Stream contract.**
  - Sources must hold valid and data stable until accepted.
  - The block holds `y_valid`, `y_data` and `y_sel` stable until taken.

## Timing
- **Reset values.** `y_valid=0`, `y_data=0`, `y_sel=0`, `pri=1`.
  - Reset takes effect immediately, without waiting for a clock edge.
  - A word held at reset is dropped.
  - After reset release, the first simultaneous request goes to A.
- **Latency.** One cycle: a word accepted at edge N appears at `y_data` after edge N.
- **Throughput.** One word per cycle with `y_ready` held high.
- **Simultaneous drain and load.** When the register drains and reloads in the same cycle, it reloads with the new word and `y_valid` stays 1.
- **Sustained contention.** With both sources continuously valid and `y_ready=1`, grants alternate strictly A, B, A, B…
- **Readys while empty.** With the register empty, the readys are high for the winning source even when `y_ready=0`.
- **Combinational paths.**
  - `y_ready` → `a_ready` / `b_ready`.
  - `a_valid` ↔ `b_ready` and `b_valid` ↔ `a_ready`.
  - There is no valid → own-ready path.

## Test plan
- **Reset.** Assert `rst` mid-stream with `y_valid=1` → `y_valid`, `y_data` and `y_sel` go to 0 without a clock edge. After release, simultaneous A=0x11 and B=0x22 → A wins first (`y_data=0x11`, `y_sel=1`).
- **Fair alternation.** Both valid, A=0xA0…, B=0xB0…, `y_ready=1` for 6 cycles → output 0xA0, 0xB0, 0xA1, 0xB1, 0xA2, 0xB2. `y_sel` reads 1,0,1,0,1,0.
- **Single requester.** Only B valid for 4 words, `y_ready=1` → 4 back-to-back B words with `a_ready` unused. Then both valid → A wins, because `pri=1` after B.
- **Backpressure.** Load 0x5C from A, then hold `y_ready=0` for 3 cycles with both sources valid → `y_data=0x5C` and `y_valid=1` stay stable, both readys stay 0, and no input is lost. Release `y_ready` → the next word is B (0xB0) in the same cycle as the drain.
- **Drain only.** With `y_valid=1`, `y_ready=1` and no sources valid → `y_valid` is 0 the next cycle, and `y_data` keeps its last value.
- **Random soak.** Random valids and random `y_ready` over 2000 cycles → the scoreboard shows no drop or duplicate, and per-source order is preserved. Under sustained contention, no source waits more than one grant.
